// File: rtl/vga_sync_gen.sv
// VGA timing generator: 2-flop lock synchronizer, WAIT_LOCK/RUN control and registered
// sync, blank, position, lookahead and pulse outputs, all aligned to the same (x,y).
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_req,
  output logic [9:0] req_x,
  output logic [9:0] req_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  localparam logic [0:0] WAIT_LOCK = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;

  logic       lock_m;
  logic       lock_s;
  logic [0:0] state;

  logic       run_n;
  logic [9:0] x_n, y_n, rx_n, ry_n;
  logic       preq_n, vis_n, hs_n, vs_n, ls_n, fs_n;

  function automatic logic [19:0] next_pos(input logic [9:0] cx, input logic [9:0] cy);
    if (cx == H_LAST)
      return {10'd0, (cy == V_LAST) ? 10'd0 : cy + 10'd1};
    else
      return {cx + 10'd1, cy};
  endfunction

  // Everything below describes the cycle after the coming edge, so the
  // registers present x/y and all derived outputs together.
  always_comb begin
    run_n  = lock_s;
    x_n    = '0;
    y_n    = '0;
    rx_n   = '0;
    ry_n   = '0;
    preq_n = 1'b0;
    if (run_n && state == RUN)
      {x_n, y_n} = next_pos(x, y);
    if (run_n) begin
      {rx_n, ry_n} = next_pos(x_n, y_n);
      preq_n       = (rx_n < H_VIS) && (ry_n < V_VIS);
    end else if (lock_m) begin
      // lock_s rises on this edge, so the following cycle is the first RUN at (0,0)
      preq_n = 1'b1;
    end
    vis_n = run_n && (x_n < H_VIS) && (y_n < V_VIS);
    hs_n  = !(run_n && (x_n >= H_SS) && (x_n < H_SE));
    vs_n  = !(run_n && (y_n >= V_SS) && (y_n < V_SE));
    ls_n  = run_n && (x_n == 10'd0);
    fs_n  = ls_n && (y_n == 10'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m      <= 1'b0;
      lock_s      <= 1'b0;
      state       <= WAIT_LOCK;
      x           <= '0;
      y           <= '0;
      req_x       <= '0;
      req_y       <= '0;
      pix_req     <= 1'b0;
      video_on    <= 1'b0;
      vga_blank_n <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      lock_m      <= locked;
      lock_s      <= lock_m;
      state       <= run_n ? RUN : WAIT_LOCK;
      x           <= x_n;
      y           <= y_n;
      req_x       <= rx_n;
      req_y       <= ry_n;
      pix_req     <= preq_n;
      video_on    <= vis_n;
      vga_blank_n <= vis_n;
      vga_hs      <= hs_n;
      vga_vs      <= vs_n;
      line_start  <= ls_n;
      frame_start <= fs_n;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: 800-clock lines, shortened 27-line frame.
module tb_vga_sync_gen;
  localparam int VV = 20, VFP = 2, VS = 2, VBP = 3;
  localparam int FRAME = 800 * (VV + VFP + VS + VBP);

  logic       clk = 1'b0;
  logic       rst, locked;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, video_on, pix_req;
  logic       line_start, frame_start;
  logic [9:0] x, y, req_x, req_y;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .video_on(video_on), .x(x), .y(y), .pix_req(pix_req), .req_x(req_x), .req_y(req_y),
    .line_start(line_start), .frame_start(frame_start)
  );

  typedef struct packed {
    logic [9:0] x, y;
    logic hs, vs, bl, sn, von, ls, fs, preq;
    logic [9:0] rx, ry;
  } out_t;

  typedef struct {
    int    cyc;
    string nm;
    out_t  v;
  } exp_t;

  exp_t sbq[$];
  out_t act;
  int   ec = 0;
  int   n_chk = 0, n_fail = 0;
  int   run_base = -1;
  int   hs_lo = 0, vs_lo = 0, ls_cnt = 0, fs_cnt = 0, von_cnt = 0;

  always_comb act = {x, y, vga_hs, vga_vs, vga_blank_n, vga_sync_n, video_on,
                     line_start, frame_start, pix_req, req_x, req_y};

  function automatic out_t mk(int xx, int yy, bit hs, bit vs, bit von, bit ls, bit fs,
                              bit preq, int rxx, int ryy);
    out_t o;
    o.x = 10'(xx);  o.y = 10'(yy);
    o.hs = hs;      o.vs = vs;
    o.bl = von;     o.sn = 1'b0;
    o.von = von;    o.ls = ls;   o.fs = fs;  o.preq = preq;
    o.rx = 10'(rxx); o.ry = 10'(ryy);
    return o;
  endfunction

  function automatic out_t waitv();
    return mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic push(input int c, input string nm, input out_t v);
    exp_t e;
    e.cyc = c; e.nm = nm; e.v = v;
    sbq.push_back(e);
  endtask

  task automatic check_int(input string nm, input int got, input int req);
    n_chk++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  always @(posedge clk) ec <= ec + 1;

  // Monitor: pops every expectation due this cycle and keeps frame statistics.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= ec) begin
      e = sbq.pop_front();
      n_chk++;
      if (e.cyc < ec || act !== e.v) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got x=%0d y=%0d hs%b vs%b bl%b sn%b von%b ls%b fs%b preq%b req=(%0d,%0d) required x=%0d y=%0d hs%b vs%b bl%b sn%b von%b ls%b fs%b preq%b req=(%0d,%0d)",
                 e.nm, ec, act.x, act.y, act.hs, act.vs, act.bl, act.sn, act.von, act.ls,
                 act.fs, act.preq, act.rx, act.ry, e.v.x, e.v.y, e.v.hs, e.v.vs, e.v.bl,
                 e.v.sn, e.v.von, e.v.ls, e.v.fs, e.v.preq, e.v.rx, e.v.ry);
      end
    end
    if (run_base >= 0 && ec >= run_base && ec < run_base + FRAME) begin
      if (!vga_hs)     hs_lo++;
      if (!vga_vs)     vs_lo++;
      if (line_start)  ls_cnt++;
      if (frame_start) fs_cnt++;
      if (video_on)    von_cnt++;
    end
  end

  function automatic int at(int b, int xx, int yy);
    return b + yy * 800 + xx;
  endfunction

  initial begin
    int e0, r, r2, p, q, r3;
    rst = 1'b1;
    locked = 1'b1;
    push(2, "reset", waitv());
    repeat (4) @(posedge clk);
    #2;
    e0 = ec;
    rst = 1'b0;
    r = e0 + 3;
    push(e0 + 1, "sync_stage1", waitv());
    push(e0 + 2, "lookahead_wait", mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    push(r, "first_run", mk(0, 0, 1, 1, 1, 1, 1, 1, 1, 0));
    push(at(r, 1, 0),    "x1",           mk(1, 0, 1, 1, 1, 0, 0, 1, 2, 0));
    push(at(r, 639, 0),  "last_visible", mk(639, 0, 1, 1, 1, 0, 0, 0, 640, 0));
    push(at(r, 640, 0),  "first_blank",  mk(640, 0, 1, 1, 0, 0, 0, 0, 641, 0));
    push(at(r, 655, 0),  "hs_before",    mk(655, 0, 1, 1, 0, 0, 0, 0, 656, 0));
    push(at(r, 656, 0),  "hs_first",     mk(656, 0, 0, 1, 0, 0, 0, 0, 657, 0));
    push(at(r, 751, 0),  "hs_last",      mk(751, 0, 0, 1, 0, 0, 0, 0, 752, 0));
    push(at(r, 752, 0),  "hs_after",     mk(752, 0, 1, 1, 0, 0, 0, 0, 753, 0));
    push(at(r, 799, 0),  "line_end",     mk(799, 0, 1, 1, 0, 0, 0, 1, 0, 1));
    push(at(r, 0, 1),    "line1_start",  mk(0, 1, 1, 1, 1, 1, 0, 1, 1, 1));
    push(at(r, 639, 10), "look_639_10",  mk(639, 10, 1, 1, 1, 0, 0, 0, 640, 10));
    push(at(r, 799, 10), "look_799_10",  mk(799, 10, 1, 1, 0, 0, 0, 1, 0, 11));
    push(at(r, 799, 19), "look_to_vblk", mk(799, 19, 1, 1, 0, 0, 0, 0, 0, 20));
    push(at(r, 0, 20),   "vblank_start", mk(0, 20, 1, 1, 0, 1, 0, 0, 1, 20));
    push(at(r, 799, 21), "vs_before",    mk(799, 21, 1, 1, 0, 0, 0, 0, 0, 22));
    push(at(r, 0, 22),   "vs_first",     mk(0, 22, 1, 0, 0, 1, 0, 0, 1, 22));
    push(at(r, 700, 23), "hs_vs_both",   mk(700, 23, 0, 0, 0, 0, 0, 0, 701, 23));
    push(at(r, 799, 23), "vs_last",      mk(799, 23, 1, 0, 0, 0, 0, 0, 0, 24));
    push(at(r, 0, 24),   "vs_after",     mk(0, 24, 1, 1, 0, 1, 0, 0, 1, 24));
    push(at(r, 799, 26), "frame_wrap",   mk(799, 26, 1, 1, 0, 0, 0, 1, 0, 0));
    r2 = r + FRAME;
    push(r2, "frame2_start", mk(0, 0, 1, 1, 1, 1, 1, 1, 1, 0));
    run_base = r;

    wait (ec == r2);
    @(negedge clk);
    #1;
    check_int("hs_low_clocks", hs_lo, 96 * 27);
    check_int("vs_low_clocks", vs_lo, 1600);
    check_int("line_starts", ls_cnt, 27);
    check_int("frame_starts", fs_cnt, 1);
    check_int("visible_clocks", von_cnt, 640 * 20);

    p = at(r2, 300, 5);
    push(p,     "pre_loss",  mk(300, 5, 1, 1, 1, 0, 0, 1, 301, 5));
    push(p + 1, "loss_e1",   mk(301, 5, 1, 1, 1, 0, 0, 1, 302, 5));
    push(p + 2, "loss_e2",   mk(302, 5, 1, 1, 1, 0, 0, 1, 303, 5));
    push(p + 3, "lock_lost", waitv());
    push(p + 6, "wait_hold", waitv());
    wait (ec == p);
    #2;
    locked = 1'b0;

    q = p + 10;
    wait (ec == q);
    #2;
    locked = 1'b1;
    r3 = q + 3;
    push(q + 1, "relock1",   waitv());
    push(q + 2, "relock2",   mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    push(r3,    "restart",   mk(0, 0, 1, 1, 1, 1, 1, 1, 1, 0));
    push(r3 + 100, "pre_reset", mk(100, 0, 1, 1, 1, 0, 0, 1, 101, 0));

    wait (ec == r3 + 101);
    #2;
    rst = 1'b1;
    push(r3 + 101, "async_reset", waitv());
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_int("queue_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: cycle %0d reached without completion", ec);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, 96, horizontal sync width in clocks.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_VISIBLE, 480, active lines per frame.
REQ-006 SHALL have parameters V_FP, 10; V_SYNC, 2; V_BP, 33: vertical porches and sync width in lines.
REQ-007 SHALL have port clk, input, 1, pixel clock (25.175 MHz PLL output); single clock domain.
REQ-008 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-009 SHALL have port locked, input, 1, PLL lock indication; asynchronous to clk.
REQ-010 SHALL have ports vga_hs and vga_vs, outputs, 1 each, active-low sync.
REQ-011 SHALL have ports vga_blank_n and vga_sync_n, outputs, 1 each, DAC blank (low outside visible area) and DAC composite sync (constant 0).
REQ-012 SHALL have port video_on, output, 1, high while position is visible.
REQ-013 SHALL have ports x and y, outputs, 10 each, current counter position.
REQ-014 SHALL have ports pix_req, output, 1, and req_x/req_y, outputs, 10 each: lookahead request for the next clock's position.
REQ-015 SHALL have ports line_start and frame_start, outputs, 1 each, single-cycle pulses.

Function
REQ-016 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL analogous (525); counters are unsigned 10-bit.
REQ-017 locked SHALL pass through a 2-flop synchronizer (lock_s) before use.
REQ-018 FSM states: WAIT_LOCK, RUN. WAIT_LOCK->RUN on the clock edge where lock_s=1; RUN->WAIT_LOCK on the edge where lock_s=0.
REQ-019 In WAIT_LOCK: x=y=0, vga_hs=vga_vs=1, vga_blank_n=0, video_on=0, pix_req=0, req_x=req_y=0, pulses 0.
REQ-020 In RUN, x increments every clock; at x=H_TOTAL-1 x wraps to 0 and y increments; at x=H_TOTAL-1 with y=V_TOTAL-1, x and y both wrap to 0.
REQ-021 The first RUN cycle SHALL present x=0, y=0.
REQ-022 All outputs SHALL be registered, and mutually aligned to the same (x,y) in the same cycle.
REQ-023 video_on=vga_blank_n=1 iff RUN and x<H_VISIBLE and y<V_VISIBLE.
REQ-024 vga_hs=0 iff RUN and H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC (656..751).
REQ-025 vga_vs=0 iff RUN and V_VISIBLE+V_FP <= y < V_VISIBLE+V_FP+V_SYNC (490..491), over entire lines.
REQ-026 line_start=1 iff RUN and x=0; frame_start=1 iff RUN and x=0 and y=0.
REQ-027 req_x/req_y SHALL equal the (x,y) the next clock will present in RUN, including wrap; pix_req=1 iff RUN and that position is visible.
REQ-028 In WAIT_LOCK with lock_s=1, req_x=req_y=0 and pix_req=1, matching the first RUN cycle.
REQ-029 Lock loss mid-frame SHALL abandon the frame; the next RUN restarts at (0,0) with frame_start.
REQ-030 locked pulses shorter than 2 clocks MAY be filtered; no other glitch filtering is performed.

Reset
REQ-031 rst=1 SHALL asynchronously force WAIT_LOCK, synchronizer flops to 0, and all outputs to REQ-019 values.
REQ-032 After rst deasserts with locked=1, RUN SHALL be entered on the third rising clk edge.
REQ-033 rst asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.

Verification
REQ-034 Lock-up: rst released, locked=1 -> x=y=0 and frame_start=1 on 3rd edge; vga_hs=vga_vs=1 before that.
REQ-035 Line timing: in RUN, across x=0..799 -> video_on=1 for x=0..639, vga_hs=0 for exactly x=656..751, line_start once per 800 clocks.
REQ-036 Frame timing: a full frame = 420000 clocks between frame_start pulses; vga_vs=0 for exactly 1600 clocks (y=490..491); wrap (799,524)->(0,0).
REQ-037 Lookahead: at (639,10) -> pix_req=0, req=(640,10); at (799,10) -> pix_req=1, req=(0,11); at (799,524) -> req=(0,0), pix_req=1.
REQ-038 Lock loss: locked=0 at (300,200) -> WAIT_LOCK after 2 edges, syncs high, blank; relock -> restart at (0,0) with frame_start.
REQ-039 Async reset: rst pulse between edges mid-frame -> outputs take REQ-019 values immediately.
